// File: rtl/adc_reader.sv
// -----------------------------------------------------------------------------
// adc_reader
//   Polls the external ADC over an 8N1 UART link and holds the most recent
//   10-bit sample. The poll loop is: wait GAP_CYCLES, send CMD_BYTE, receive a
//   high byte and a low byte, publish {hi[1:0], lo}. A missing reply byte or a
//   byte with a bad stop bit abandons the poll with a timeout pulse.
//
// Ports
//   clock12MHz  in   1   system clock, all logic on the rising edge
//   reset       in   1   synchronous, active-high reset
//   serialIn    in   1   UART RX from the ADC controller (async, idle high)
//   serialOut   out  1   UART TX to the ADC controller (idle high)
//   value       out  10  latest valid sample, held between updates
//   valid       out  1   one-cycle pulse when value is updated
//   timeout     out  1   one-cycle pulse when a poll is abandoned
// -----------------------------------------------------------------------------
module adc_reader #(
  parameter int         CLK_DIV     = 104,
  parameter logic [7:0] CMD_BYTE    = 8'hA1,
  parameter int         GAP_CYCLES  = 12000,
  parameter int         TIMEOUT_CYC = 120000
) (
  input  logic       clock12MHz,
  input  logic       reset,
  input  logic       serialIn,
  output logic       serialOut,
  output logic [9:0] value,
  output logic       valid,
  output logic       timeout
);

  // Bit-period counter width; at least one bit even for a degenerate divider.
  localparam int BIT_W   = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  // One counter serves both the idle gap and the reply timer.
  localparam int SEQ_MAX = (GAP_CYCLES > TIMEOUT_CYC) ? GAP_CYCLES : TIMEOUT_CYC;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLK_DIV / 2 - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST  = SEQ_W'(GAP_CYCLES);
  localparam logic [SEQ_W-1:0] TMO_LAST  = SEQ_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    SQ_GAP     = 2'd0,
    SQ_SEND    = 2'd1,
    SQ_WAIT_HI = 2'd2,
    SQ_WAIT_LO = 2'd3
  } seq_state_t;

  // ---------------------------------------------------------------------------
  // Transmitter state
  // ---------------------------------------------------------------------------
  logic             r_tx_out;
  logic             r_tx_busy;
  logic [8:0]       r_tx_shift;   // remaining bits after the start bit: {stop, d7..d0}
  logic [3:0]       r_tx_bit;
  logic [BIT_W-1:0] r_tx_cnt;
  logic             r_tx_done;    // one-cycle pulse after the stop bit has ended

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  logic             r_rx_sync1;
  logic             r_rx_sync2;   // synchronised line level
  logic             r_rx_sync3;   // previous synchronised level, for edge detect
  rx_state_t        r_rx_state;
  rx_state_t        w_rx_next;
  logic [BIT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_rx_byte;
  logic             r_rx_done;
  logic             r_rx_err;
  logic             w_rx_cnt_clr;
  logic             w_rx_sample;
  logic             w_rx_done;
  logic             w_rx_err;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  seq_state_t       r_seq_state;
  seq_state_t       w_seq_next;
  logic [SEQ_W-1:0] r_seq_cnt;
  logic [1:0]       r_hi_bits;    // only hi[1:0] contributes to the sample
  logic [9:0]       r_value;
  logic             r_valid;
  logic             r_timeout;
  logic             w_seq_cnt_clr;
  logic             w_tx_start;
  logic             w_hi_load;
  logic             w_valid;
  logic             w_timeout;

  // ===========================================================================
  // Transmitter
  // ===========================================================================

  // TX shifter: start bit on load, then d0..d7 and stop, each CLK_DIV cycles.
  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      r_tx_out   <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_shift <= 9'h1FF;
      r_tx_bit   <= 4'd0;
      r_tx_cnt   <= {BIT_W{1'b0}};
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (w_tx_start) begin
        r_tx_out   <= 1'b0;
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, CMD_BYTE};
        r_tx_bit   <= 4'd0;
        r_tx_cnt   <= {BIT_W{1'b0}};
      end else if (r_tx_busy) begin
        if (r_tx_cnt == BIT_LAST) begin
          r_tx_cnt <= {BIT_W{1'b0}};
          if (r_tx_bit == 4'd9) begin
            // Stop bit has run its full period: frame complete.
            r_tx_busy <= 1'b0;
            r_tx_out  <= 1'b1;
            r_tx_done <= 1'b1;
          end else begin
            r_tx_out   <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[8:1]};
            r_tx_bit   <= r_tx_bit + 4'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + BIT_W'(1);
        end
      end else begin
        r_tx_out <= 1'b1;
      end
    end
  end

  // ===========================================================================
  // Receiver
  // ===========================================================================

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_sync3 <= 1'b1;
    end else begin
      r_rx_sync1 <= serialIn;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_sync3 <= r_rx_sync2;
    end
  end

  // RX next-state: edge-triggered start, mid-bit recheck, centred sampling.
  always_comb begin
    w_rx_next    = r_rx_state;
    w_rx_cnt_clr = 1'b0;
    w_rx_sample  = 1'b0;
    w_rx_done    = 1'b0;
    w_rx_err     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_clr = 1'b1;
        // A true falling edge is required, so a line left low after a
        // framing error does not retrigger a frame.
        if (r_rx_sync3 && !r_rx_sync2) begin
          w_rx_next = RX_START;
        end else begin
          w_rx_next = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_clr = 1'b1;
          // Line high again at mid start bit: it was a glitch.
          if (r_rx_sync2) begin
            w_rx_next = RX_IDLE;
          end else begin
            w_rx_next = RX_DATA;
          end
        end else begin
          w_rx_next = RX_START;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_clr = 1'b1;
          w_rx_sample  = 1'b1;
          if (r_rx_bit == 3'd7) begin
            w_rx_next = RX_STOP;
          end else begin
            w_rx_next = RX_DATA;
          end
        end else begin
          w_rx_next = RX_DATA;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_clr = 1'b1;
          w_rx_next    = RX_IDLE;
          if (r_rx_sync2) begin
            w_rx_done = 1'b1;
          end else begin
            w_rx_err = 1'b1;
          end
        end else begin
          w_rx_next = RX_STOP;
        end
      end
      default: begin
        w_rx_next    = RX_IDLE;
        w_rx_cnt_clr = 1'b1;
      end
    endcase
  end

  // RX state register, bit timer, data shifter and result pulses.
  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= {BIT_W{1'b0}};
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_done  <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_done  <= w_rx_done;
      r_rx_err   <= w_rx_err;
      if (w_rx_cnt_clr) begin
        r_rx_cnt <= {BIT_W{1'b0}};
      end else begin
        r_rx_cnt <= r_rx_cnt + BIT_W'(1);
      end
      if (w_rx_sample) begin
        // LSB arrives first, so shift in from the top.
        r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end else if (r_rx_state != RX_DATA) begin
        r_rx_bit <= 3'd0;
      end else begin
        r_rx_bit <= r_rx_bit;
      end
      if (w_rx_done) begin
        r_rx_byte <= r_rx_shift;
      end else begin
        r_rx_byte <= r_rx_byte;
      end
    end
  end

  // ===========================================================================
  // Polling sequencer
  // ===========================================================================

  // Sequencer next-state and control strobes.
  always_comb begin
    w_seq_next    = r_seq_state;
    w_seq_cnt_clr = 1'b0;
    w_tx_start    = 1'b0;
    w_hi_load     = 1'b0;
    w_valid       = 1'b0;
    w_timeout     = 1'b0;
    case (r_seq_state)
      SQ_GAP: begin
        // Replies arriving here are ignored; only the counter matters.
        if (r_seq_cnt == GAP_LAST) begin
          w_seq_next    = SQ_SEND;
          w_seq_cnt_clr = 1'b1;
          w_tx_start    = 1'b1;
        end else begin
          w_seq_next = SQ_GAP;
        end
      end
      SQ_SEND: begin
        w_seq_cnt_clr = 1'b1;
        if (r_tx_done) begin
          w_seq_next = SQ_WAIT_HI;
        end else begin
          w_seq_next = SQ_SEND;
        end
      end
      SQ_WAIT_HI: begin
        if (r_rx_done) begin
          w_hi_load     = 1'b1;
          w_seq_cnt_clr = 1'b1;
          w_seq_next    = SQ_WAIT_LO;
        end else if (r_rx_err || (r_seq_cnt == TMO_LAST)) begin
          w_timeout     = 1'b1;
          w_seq_cnt_clr = 1'b1;
          w_seq_next    = SQ_GAP;
        end else begin
          w_seq_next = SQ_WAIT_HI;
        end
      end
      SQ_WAIT_LO: begin
        if (r_rx_done) begin
          w_valid       = 1'b1;
          w_seq_cnt_clr = 1'b1;
          w_seq_next    = SQ_GAP;
        end else if (r_rx_err || (r_seq_cnt == TMO_LAST)) begin
          w_timeout     = 1'b1;
          w_seq_cnt_clr = 1'b1;
          w_seq_next    = SQ_GAP;
        end else begin
          w_seq_next = SQ_WAIT_LO;
        end
      end
      default: begin
        w_seq_next    = SQ_GAP;
        w_seq_cnt_clr = 1'b1;
      end
    endcase
  end

  // Sequencer state register, shared gap/timeout counter and sample latch.
  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      r_seq_state <= SQ_GAP;
      r_seq_cnt   <= {SEQ_W{1'b0}};
      r_hi_bits   <= 2'b00;
      r_value     <= 10'h000;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_seq_state <= w_seq_next;
      r_valid     <= w_valid;
      r_timeout   <= w_timeout;
      if (w_seq_cnt_clr) begin
        r_seq_cnt <= {SEQ_W{1'b0}};
      end else begin
        r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
      end
      if (w_hi_load) begin
        r_hi_bits <= r_rx_byte[1:0];
      end else begin
        r_hi_bits <= r_hi_bits;
      end
      // Both halves are committed together so value is never half-updated.
      if (w_valid) begin
        r_value <= {r_hi_bits, r_rx_byte};
      end else begin
        r_value <= r_value;
      end
    end
  end

  assign serialOut = r_tx_out;
  assign value     = r_value;
  assign valid     = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_adc_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_reader
//   Self-checking bench for adc_reader. Plays the ADC controller: decodes the
//   command frame, answers with scripted or random replies (good, silent, bad
//   stop bit, glitch), and predicts value/valid/timeout from the reply rules.
// -----------------------------------------------------------------------------
module tb_adc_reader;

  localparam int         CLK_DIV = 104;
  localparam logic [7:0] CMD     = 8'hA1;
  localparam int         GAP     = 400;
  localparam int         TMO     = 2500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       ser_out;
  logic [9:0] val;
  logic       vld;
  logic       tmo;

  always #5 clk = ~clk;

  adc_reader #(
    .CLK_DIV    (CLK_DIV),
    .CMD_BYTE   (CMD),
    .GAP_CYCLES (GAP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clock12MHz(clk),
    .reset     (rst),
    .serialIn  (rx_line),
    .serialOut (ser_out),
    .value     (val),
    .valid     (vld),
    .timeout   (tmo)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Pulse monitor (runs while the main thread is busy driving bytes).
  int         valid_cnt = 0;
  int         timeout_cnt = 0;
  int         both_cnt = 0;
  int         last_pulse_cyc = 0;
  logic [9:0] last_valid_value = 10'h000;

  // Reference model state.
  int exp_value = 0;
  int stop_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld === 1'b1) begin
      valid_cnt        <= valid_cnt + 1;
      last_valid_value <= val;
      last_pulse_cyc   <= cyc;
    end
    if (tmo === 1'b1) begin
      timeout_cnt    <= timeout_cnt + 1;
      last_pulse_cyc <= cyc;
    end
    if (vld === 1'b1 && tmo === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one UART frame (or its first nbits bits) on serialIn.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) rx_line = 1'b0;
      else if (i < 9) rx_line = b[i-1];
      else begin
        rx_line  = stop_bit;
        stop_cyc = cyc;
      end
      repeat (CLK_DIV) @(negedge clk);
    end
    if (nbits == 10) rx_line = 1'b1;
  endtask

  // Wait (bounded) for a start bit on serialOut.
  task automatic wait_start(output int start_cyc, output bit ok);
    int n = 0;
    while (ser_out === 1'b1 && n < GAP + 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (ser_out === 1'b0);
    start_cyc = cyc;
  endtask

  // Capture a full command frame, counting samples off the ideal waveform.
  task automatic capture_frame(output int errs, output logic [7:0] b);
    logic [7:0] cmd_v = CMD;
    logic       e;
    int         k;
    errs = 0;
    b = 8'h00;
    for (int i = 0; i < 10 * CLK_DIV; i++) begin
      if (i > 0) @(negedge clk);
      k = i / CLK_DIV;
      if (k == 0) e = 1'b0;
      else if (k < 9) e = cmd_v[k-1];
      else e = 1'b1;
      if (ser_out !== e) errs++;
      if ((i % CLK_DIV) == CLK_DIV / 2 && k >= 1 && k <= 8) b[k-1] = ser_out;
    end
  endtask

  // scen: 0 good, 1 silent, 2 bad stop on hi, 3 glitch then good, 4 bad stop on lo
  task automatic run_poll(input int scen, input logic [7:0] hi, input logic [7:0] lo,
                          input int ref_cyc, input bit chk_gap, output int next_ref);
    int v0 = valid_cnt;
    int t0 = timeout_cnt;
    int sc, errs, tx_end, n, exp_v, exp_t, lat;
    bit ok;
    logic [7:0] b;
    next_ref = ref_cyc;
    wait_start(sc, ok);
    check_val("poll_start", int'(ok), 1);
    if (!ok) return;
    if (chk_gap) check_val("gap_len", sc - ref_cyc, GAP + 1);
    capture_frame(errs, b);
    check_val("tx_frame_errs", errs, 0);
    check_val("tx_byte", int'(b), int'(CMD));
    tx_end = cyc;
    exp_v = 0;
    exp_t = 0;
    if (scen != 1) repeat ($urandom_range(3, 40)) @(negedge clk);
    case (scen)
      0, 3: begin
        if (scen == 3) begin
          rx_line = 1'b0;
          repeat (30) @(negedge clk);
          rx_line = 1'b1;
          repeat (200) @(negedge clk);
        end
        send_byte(hi, 1'b1, 10);
        repeat ($urandom_range(0, 30)) @(negedge clk);
        send_byte(lo, 1'b1, 10);
        exp_value = (int'(hi) % 4) * 256 + int'(lo);
        exp_v = 1;
      end
      1: exp_t = 1;
      2: begin
        send_byte(hi, 1'b0, 10);
        exp_t = 1;
      end
      default: begin
        send_byte(hi, 1'b1, 10);
        send_byte(lo, 1'b0, 10);
        exp_t = 1;
      end
    endcase
    n = 0;
    while (valid_cnt == v0 && timeout_cnt == t0 && n < TMO + 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_val("valid_pulses", valid_cnt - v0, exp_v);
    check_val("timeout_pulses", timeout_cnt - t0, exp_t);
    check_val("value", int'(val), exp_value);
    if (exp_v == 1) begin
      check_val("valid_value", int'(last_valid_value), exp_value);
      lat = last_pulse_cyc - stop_cyc;
      check_val("valid_latency_ok", int'(lat >= CLK_DIV / 2 && lat <= CLK_DIV / 2 + 8), 1);
    end
    if (scen == 1) begin
      lat = last_pulse_cyc - tx_end;
      check_val("timeout_latency_ok", int'(lat >= TMO && lat <= TMO + 6), 1);
    end
    next_ref = last_pulse_cyc;
  endtask

  initial begin
    int ref_c, sc, v0, t0, scen;
    bit ok;
    logic [7:0] hi, lo;

    // Reset held for 5 cycles.
    rst = 1'b1;
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    check_val("rst_serial_out", int'(ser_out), 1);
    check_val("rst_value", int'(val), 0);
    check_val("rst_pulses", int'(vld) + int'(tmo), 0);
    rst = 1'b0;
    ref_c = cyc;

    run_poll(0, 8'h02, 8'h5A, ref_c, 1'b1, ref_c);
    run_poll(1, 8'h00, 8'h00, ref_c, 1'b1, ref_c);
    run_poll(0, 8'hFF, 8'hFF, ref_c, 1'b1, ref_c);
    run_poll(2, 8'h01, 8'h23, ref_c, 1'b1, ref_c);
    run_poll(3, 8'hC1, 8'h7E, ref_c, 1'b1, ref_c);
    run_poll(4, 8'h03, 8'h11, ref_c, 1'b1, ref_c);

    for (int i = 0; i < 5; i++) begin
      scen = $urandom_range(0, 4);
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      run_poll(scen, hi, lo, ref_c, 1'b1, ref_c);
    end

    // Reset in the middle of the command frame.
    wait_start(sc, ok);
    check_val("abort_start", int'(ok), 1);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("tx_abort_high", int'(ser_out), 1);
    check_val("tx_abort_value", int'(val), 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    ref_c = cyc;
    exp_value = 0;
    run_poll(0, 8'h02, 8'h5A, ref_c, 1'b1, ref_c);

    // Reset while the low byte is arriving.
    v0 = valid_cnt;
    t0 = timeout_cnt;
    wait_start(sc, ok);
    check_val("midrx_start", int'(ok), 1);
    repeat (10 * CLK_DIV + 10) @(negedge clk);
    send_byte(8'h01, 1'b1, 10);
    send_byte(8'hCC, 1'b1, 5);
    rst = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    check_val("midrx_value", int'(val), 0);
    check_val("midrx_serial_out", int'(ser_out), 1);
    repeat (4) @(negedge clk);
    check_val("midrx_no_pulses", (valid_cnt - v0) + (timeout_cnt - t0), 0);
    rst = 1'b0;
    ref_c = cyc;
    exp_value = 0;
    run_poll(0, 8'hFE, 8'h3C, ref_c, 1'b1, ref_c);

    check_val("valid_and_timeout_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
